// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency req/ack data memory: issues aligned
// loads/stores, stalls the pipeline until the response arrives, and extends load data.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_mem_funct3,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic        i_dmem_ack,
  input  logic        i_dmem_err,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_wb_kill,
  output logic [31:0] o_load_data,
  output logic        o_misalign,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       offset_q, offset_d;
  logic [31:0]      loadData_q, loadData_d;
  logic             misalign_q, misalign_d;
  logic             busErr_q, busErr_d;

  logic             isAccess;
  logic             aligned;
  logic             start;
  logic [3:0]       reqStrb;
  logic [31:0]      reqWdata;
  logic [31:0]      laneShifted;
  logic [31:0]      loadExt;

  // funct3[1:0] encodes the access size: 00 byte, 01 half, anything else a word.
  always_comb begin
    isAccess = i_mem_read | i_mem_write;
    case (i_mem_funct3[1:0])
      2'b00: begin
        aligned  = 1'b1;
        reqStrb  = 4'b0001 << i_mem_addr[1:0];
        reqWdata = {4{i_mem_wdata[7:0]}};
      end
      2'b01: begin
        aligned  = ~i_mem_addr[0];
        reqStrb  = 4'b0011 << i_mem_addr[1:0];
        reqWdata = {2{i_mem_wdata[15:0]}};
      end
      default: begin
        aligned  = (i_mem_addr[1:0] == 2'b00);
        reqStrb  = 4'b1111;
        reqWdata = i_mem_wdata;
      end
    endcase
    if (!i_mem_write) begin
      reqStrb = 4'b0000;
    end
    start = isAccess & aligned;
  end

  always_comb begin
    laneShifted = i_dmem_rdata >> {offset_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   loadExt = funct3_q[2] ? {24'b0, laneShifted[7:0]}
                                     : {{24{laneShifted[7]}}, laneShifted[7:0]};
      2'b01:   loadExt = funct3_q[2] ? {16'b0, laneShifted[15:0]}
                                     : {{16{laneShifted[15]}}, laneShifted[15:0]};
      default: loadExt = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    funct3_d   = funct3_q;
    offset_d   = offset_q;
    loadData_d = loadData_q;
    misalign_d = 1'b0;
    busErr_d   = 1'b0;
    o_stall    = 1'b0;
    o_wb_kill  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          o_stall   = 1'b1;
          o_wb_kill = 1'b1;
          req_d     = 1'b1;
          we_d      = i_mem_write;
          addr_d    = {i_mem_addr[31:2], 2'b00};
          wdata_d   = reqWdata;
          wstrb_d   = reqStrb;
          funct3_d  = i_mem_funct3;
          offset_d  = i_mem_addr[1:0];
          cnt_d     = '0;
          state_d   = BUSY;
        end else if (isAccess) begin
          misalign_d = 1'b1;
        end
      end
      BUSY: begin
        o_stall   = 1'b1;
        o_wb_kill = 1'b1;
        // A timeout is handled exactly like a bus error; err also beats a same-cycle ack.
        if (i_dmem_err || (!i_dmem_ack && (cnt_q == CntLast))) begin
          loadData_d = '0;
          busErr_d   = 1'b1;
          req_d      = 1'b0;
          state_d    = DONE;
        end else if (i_dmem_ack) begin
          loadData_d = we_q ? 32'h0 : loadExt;
          req_d      = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      funct3_q   <= '0;
      offset_q   <= '0;
      loadData_q <= '0;
      misalign_q <= 1'b0;
      busErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      funct3_q   <= funct3_d;
      offset_q   <= offset_d;
      loadData_q <= loadData_d;
      misalign_q <= misalign_d;
      busErr_q   <= busErr_d;
    end
  end

  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_wstrb = wstrb_q;
  assign o_load_data  = loadData_q;
  assign o_misalign   = misalign_q;
  assign o_bus_err    = busErr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: table of accesses replayed against a
// bench-side memory responder, plus hand-written reset-during-BUSY sequence.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_mem_read, i_mem_write;
  logic [2:0]  i_mem_funct3;
  logic [31:0] i_mem_addr, i_mem_wdata;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_wstrb;
  logic        i_dmem_ack, i_dmem_err;
  logic [31:0] i_dmem_rdata;
  logic        o_stall, o_wb_kill;
  logic [31:0] o_load_data;
  logic        o_misalign, o_bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackDelay;
    logic        err;
    logic        expMis;
    logic [31:0] expAddr;
    logic        expWe;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
    int          expStall;
    logic        expBusErr;
  } vec_t;

  vec_t vecs[17];

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_funct3(i_mem_funct3),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_ack(i_dmem_ack), .i_dmem_err(i_dmem_err), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_wb_kill(o_wb_kill), .o_load_data(o_load_data),
    .o_misalign(o_misalign), .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int stallCnt = 0;
    int reqCnt = 0;
    bit finished = 0;
    logic [31:0] expLoad;
    @(negedge clk);
    i_mem_read = v.rd; i_mem_write = v.wr; i_mem_funct3 = v.f3;
    i_mem_addr = v.addr; i_mem_wdata = v.wdata; i_dmem_rdata = v.rdata;
    i_dmem_ack = 1'b0; i_dmem_err = 1'b0;
    if (v.expMis) begin
      #1;
      checkOutput($sformatf("v%0d stall_mis", idx), {31'b0, o_stall}, 32'd0);
      @(negedge clk);
      i_mem_read = 1'b0; i_mem_write = 1'b0;
      #1;
      checkOutput($sformatf("v%0d misalign_pulse", idx), {31'b0, o_misalign}, 32'd1);
      checkOutput($sformatf("v%0d req_mis", idx), {31'b0, o_dmem_req}, 32'd0);
      @(negedge clk);
      #1;
      checkOutput($sformatf("v%0d misalign_end", idx), {31'b0, o_misalign}, 32'd0);
      return;
    end
    expQ.push_back(v.expLoad);
    for (int cyc = 0; cyc < 20 && !finished; cyc++) begin
      #1;
      if (o_dmem_req) begin
        if (reqCnt == 0) begin
          checkOutput($sformatf("v%0d addr", idx), o_dmem_addr, v.expAddr);
          checkOutput($sformatf("v%0d we", idx), {31'b0, o_dmem_we}, {31'b0, v.expWe});
          checkOutput($sformatf("v%0d wstrb", idx), {28'b0, o_dmem_wstrb}, {28'b0, v.expStrb});
          if (v.expWe) checkOutput($sformatf("v%0d wdata", idx), o_dmem_wdata, v.expWdata);
        end
        i_dmem_ack = (v.ackDelay >= 0) && (reqCnt == v.ackDelay);
        i_dmem_err = v.err && (reqCnt == v.ackDelay);
        reqCnt++;
      end else begin
        i_dmem_ack = 1'b0;
        i_dmem_err = 1'b0;
      end
      if (o_stall) begin
        stallCnt++;
        checkOutput($sformatf("v%0d wb_kill_stall", idx), {31'b0, o_wb_kill}, 32'd1);
        @(negedge clk);
      end else begin
        finished = 1;
        expLoad = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
        checkOutput($sformatf("v%0d load_data", idx), o_load_data, expLoad);
        checkOutput($sformatf("v%0d wb_kill_done", idx), {31'b0, o_wb_kill}, 32'd0);
        checkOutput($sformatf("v%0d bus_err", idx), {31'b0, o_bus_err}, {31'b0, v.expBusErr});
        checkOutput($sformatf("v%0d stall_cycles", idx), stallCnt, v.expStall);
        checkOutput($sformatf("v%0d req_cycles", idx), reqCnt, v.expStall - 1);
      end
    end
    if (!finished) begin
      checkOutput($sformatf("v%0d completion", idx), 32'd0, 32'd1);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end
    // Inputs stayed asserted through DONE; the next cycle must not show a re-issue.
    @(negedge clk);
    i_mem_read = 1'b0; i_mem_write = 1'b0;
    #1;
    checkOutput($sformatf("v%0d no_reissue", idx), {31'b0, o_dmem_req}, 32'd0);
    checkOutput($sformatf("v%0d bus_err_end", idx), {31'b0, o_bus_err}, 32'd0);
    checkOutput($sformatf("v%0d load_hold", idx), o_load_data, v.expLoad);
  endtask

  initial begin
    vec_t pre;
    //          rd wr f3      addr        wdata         rdata         dly err mis eAddr       eWe eStrb    eWdata        eLoad         stl bus
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF,  2, 0, 0, 32'h100, 0, 4'b0000, 32'h0,        32'hDEADBEEF, 4, 0};
    vecs[1]  = '{1, 0, 3'b000, 32'h203, 32'h0,        32'h80FF0000,  0, 0, 0, 32'h200, 0, 4'b0000, 32'h0,        32'hFFFFFF80, 2, 0};
    vecs[2]  = '{1, 0, 3'b100, 32'h203, 32'h0,        32'h80FF0000,  0, 0, 0, 32'h200, 0, 4'b0000, 32'h0,        32'h00000080, 2, 0};
    vecs[3]  = '{1, 0, 3'b001, 32'h202, 32'h0,        32'h80FF0000,  1, 0, 0, 32'h200, 0, 4'b0000, 32'h0,        32'hFFFF80FF, 3, 0};
    vecs[4]  = '{1, 0, 3'b101, 32'h200, 32'h0,        32'h12348001,  0, 0, 0, 32'h200, 0, 4'b0000, 32'h0,        32'h00008001, 2, 0};
    vecs[5]  = '{0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0,         0, 0, 0, 32'h300, 1, 4'b1100, 32'hABCDABCD, 32'h0,        2, 0};
    vecs[6]  = '{0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0,         1, 0, 0, 32'h300, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,        3, 0};
    vecs[7]  = '{0, 1, 3'b010, 32'h404, 32'h12345678, 32'hFFFFFFFF,  1, 0, 0, 32'h404, 1, 4'b1111, 32'h12345678, 32'h0,        3, 0};
    vecs[8]  = '{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,         0, 0, 1, 32'h0,   0, 4'b0000, 32'h0,        32'h0,        0, 0};
    vecs[9]  = '{1, 0, 3'b001, 32'h203, 32'h0,        32'h0,         0, 0, 1, 32'h0,   0, 4'b0000, 32'h0,        32'h0,        0, 0};
    vecs[10] = '{1, 1, 3'b010, 32'h500, 32'hCAFEF00D, 32'h11111111,  0, 0, 0, 32'h500, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        2, 0};
    vecs[11] = '{1, 0, 3'b011, 32'h600, 32'h0,        32'h87654321,  0, 0, 0, 32'h600, 0, 4'b0000, 32'h0,        32'h87654321, 2, 0};
    vecs[12] = '{1, 0, 3'b000, 32'h201, 32'h0,        32'h00007F00,  0, 0, 0, 32'h200, 0, 4'b0000, 32'h0,        32'h0000007F, 2, 0};
    vecs[13] = '{1, 0, 3'b010, 32'h700, 32'h0,        32'h55555555, -1, 0, 0, 32'h700, 0, 4'b0000, 32'h0,        32'h0,        5, 1};
    vecs[14] = '{1, 0, 3'b010, 32'h704, 32'h0,        32'h66666666,  1, 1, 0, 32'h704, 0, 4'b0000, 32'h0,        32'h0,        3, 1};
    vecs[15] = '{0, 1, 3'b010, 32'h102, 32'h0,        32'h0,         0, 0, 1, 32'h0,   0, 4'b0000, 32'h0,        32'h0,        0, 0};
    vecs[16] = '{0, 1, 3'b001, 32'h305, 32'h0,        32'h0,         0, 0, 1, 32'h0,   0, 4'b0000, 32'h0,        32'h0,        0, 0};

    resetn = 1'b0;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_funct3 = 3'b000;
    i_mem_addr = '0; i_mem_wdata = '0;
    i_dmem_ack = 1'b0; i_dmem_err = 1'b0; i_dmem_rdata = '0;
    #2;
    checkOutput("rst req", {31'b0, o_dmem_req}, 32'd0);
    checkOutput("rst we", {31'b0, o_dmem_we}, 32'd0);
    checkOutput("rst addr", o_dmem_addr, 32'd0);
    checkOutput("rst wdata", o_dmem_wdata, 32'd0);
    checkOutput("rst wstrb", {28'b0, o_dmem_wstrb}, 32'd0);
    checkOutput("rst load", o_load_data, 32'd0);
    checkOutput("rst misalign", {31'b0, o_misalign}, 32'd0);
    checkOutput("rst bus_err", {31'b0, o_bus_err}, 32'd0);
    checkOutput("rst stall", {31'b0, o_stall}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] reset during BUSY sequence");
    pre = '{1, 0, 3'b010, 32'h800, 32'h0, 32'h0BADF00D, 0, 0, 0, 32'h800, 0, 4'b0000, 32'h0, 32'h0BADF00D, 2, 0};
    applyStimulus(pre, 100);
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_funct3 = 3'b010; i_mem_addr = 32'h108;
    i_dmem_ack = 1'b0; i_dmem_err = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rstseq req_busy", {31'b0, o_dmem_req}, 32'd1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    i_mem_read = 1'b0;
    #1;
    checkOutput("rstseq req", {31'b0, o_dmem_req}, 32'd0);
    checkOutput("rstseq stall", {31'b0, o_stall}, 32'd0);
    checkOutput("rstseq load", o_load_data, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("rstseq idle_req", {31'b0, o_dmem_req}, 32'd0);
    pre = '{1, 0, 3'b010, 32'h10C, 32'h0, 32'hA5A55A5A, 1, 0, 0, 32'h10C, 0, 4'b0000, 32'h0, 32'hA5A55A5A, 3, 0};
    applyStimulus(pre, 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
